// File: rtl/fence_cache_sequencer.sv
// rtl/fence_cache_sequencer.sv - orders FENCE/FENCE.I into dcache flush and icache clear phases
// Optional macro FENCE_TIMEOUT_EN adds a per-phase watchdog that forces DONE and pulses fence_timeout.
module fence_cache_sequencer #(
  parameter int DCACHE_WRITEBACK = 1,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic fence_i_req,
  input  logic fence_d_req,
  input  logic amo_reserve,
  input  logic amo_exclusive,
  output logic fence_busy,
  output logic fence_done,
  output logic fence_timeout,
  output logic icache_clear,
  output logic icache_flush,
  output logic dcache_clear,
  output logic dcache_flush,
  output logic dcache_reserve,
  output logic dcache_exclusive,
  input  logic iclear_done,
  input  logic iflush_done,
  input  logic dclear_done,
  input  logic dflush_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_D_FLUSH = 2'd1,
    S_I_CLEAR = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam bit WB = (DCACHE_WRITEBACK != 0);

  state_t r_state;
  state_t w_next;
  logic   r_op_i;
  logic   w_op_i;
  logic   r_timeout;
  logic   w_timeout;
  logic   w_expired;
  logic   w_unused;

`ifdef FENCE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  // Any state change clears the count, so each wait phase starts from zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (r_state != w_next) begin
      r_cnt <= '0;
    end else if (r_cnt != CW'(TIMEOUT_CYCLES)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_expired = (r_cnt == CW'(TIMEOUT_CYCLES));
  assign w_unused  = &{1'b0, iflush_done, dclear_done};
`else
  assign w_expired = 1'b0;
  assign w_unused  = &{1'b0, iflush_done, dclear_done, (TIMEOUT_CYCLES > 0)};
`endif

  always_comb begin
    w_next    = r_state;
    w_op_i    = r_op_i;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fence_i_req) begin
          w_op_i = 1'b1;
          w_next = WB ? S_D_FLUSH : S_I_CLEAR;
        end else if (fence_d_req) begin
          w_op_i = 1'b0;
          w_next = WB ? S_D_FLUSH : S_DONE;
        end
      end
      S_D_FLUSH: begin
        if (dflush_done) begin
          w_next = r_op_i ? S_I_CLEAR : S_DONE;
        end else if (w_expired) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_I_CLEAR: begin
        if (iclear_done) begin
          w_next = S_DONE;
        end else if (w_expired) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_op_i    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_op_i    <= w_op_i;
      r_timeout <= w_timeout;
    end
  end

  assign dcache_flush     = (r_state == S_D_FLUSH);
  assign icache_clear     = (r_state == S_I_CLEAR);
  assign fence_done       = (r_state == S_DONE);
  assign fence_timeout    = r_timeout;
  assign icache_flush     = 1'b0;
  assign dcache_clear     = 1'b0;
  assign dcache_reserve   = amo_reserve;
  assign dcache_exclusive = amo_exclusive & (r_state == S_IDLE);
  assign fence_busy       = ((r_state != S_IDLE) && (r_state != S_DONE)) ||
                            ((r_state == S_IDLE) && (fence_i_req || fence_d_req));

endmodule

// File: tb/tb_fence_cache_sequencer.sv
// tb/tb_fence_cache_sequencer.sv - directed self-checking bench for fence_cache_sequencer
module tb_fence_cache_sequencer;

  logic CLK;
  logic RST;
  logic fi, fd, amo_r, amo_x, ic_done, if_done, dc_done, df_done;
  logic busy, done, tmo, ic_clr, ic_fl, dc_clr, dc_fl, dc_res, dc_exc;
  logic fi2, fd2, ic_done2, df_done2;
  logic busy2, done2, tmo2, ic_clr2, ic_fl2, dc_clr2, dc_fl2, dc_res2, dc_exc2;

  int n_checks = 0;
  int n_errors = 0;

  fence_cache_sequencer #(.DCACHE_WRITEBACK(1), .TIMEOUT_CYCLES(8)) u_dut (
    .CLK(CLK), .RST(RST), .fence_i_req(fi), .fence_d_req(fd),
    .amo_reserve(amo_r), .amo_exclusive(amo_x),
    .fence_busy(busy), .fence_done(done), .fence_timeout(tmo),
    .icache_clear(ic_clr), .icache_flush(ic_fl), .dcache_clear(dc_clr), .dcache_flush(dc_fl),
    .dcache_reserve(dc_res), .dcache_exclusive(dc_exc),
    .iclear_done(ic_done), .iflush_done(if_done), .dclear_done(dc_done), .dflush_done(df_done)
  );

  fence_cache_sequencer #(.DCACHE_WRITEBACK(0), .TIMEOUT_CYCLES(8)) u_dut_wt (
    .CLK(CLK), .RST(RST), .fence_i_req(fi2), .fence_d_req(fd2),
    .amo_reserve(1'b0), .amo_exclusive(1'b0),
    .fence_busy(busy2), .fence_done(done2), .fence_timeout(tmo2),
    .icache_clear(ic_clr2), .icache_flush(ic_fl2), .dcache_clear(dc_clr2), .dcache_flush(dc_fl2),
    .dcache_reserve(dc_res2), .dcache_exclusive(dc_exc2),
    .iclear_done(ic_done2), .iflush_done(1'b0), .dclear_done(1'b0), .dflush_done(df_done2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dut(input string tag, input logic e_busy, input logic e_done,
                           input logic e_flush, input logic e_iclr, input logic e_tmo);
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    check({tag, ".dflush"}, {31'd0, dc_fl}, {31'd0, e_flush});
    check({tag, ".iclear"}, {31'd0, ic_clr}, {31'd0, e_iclr});
    check({tag, ".timeout"}, {31'd0, tmo}, {31'd0, e_tmo});
    check({tag, ".tied"}, {30'd0, ic_fl, dc_clr}, 32'd0);
  endtask

  task automatic cyc();
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1; fi = 1'b1; fd = 1'b0; amo_r = 1'b0; amo_x = 1'b0;
    ic_done = 1'b0; if_done = 1'b0; dc_done = 1'b0; df_done = 1'b0;
    fi2 = 1'b0; fd2 = 1'b0; ic_done2 = 1'b0; df_done2 = 1'b0;

    // Reset held with a pending FENCE.I: no cache request may appear.
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      check("rst.dflush", {31'd0, dc_fl}, 32'd0);
      check("rst.iclear", {31'd0, ic_clr}, 32'd0);
      check("rst.done", {31'd0, done}, 32'd0);
      check("rst.timeout", {31'd0, tmo}, 32'd0);
    end
    cyc(); RST = 1'b0; fi = 1'b0; #1;
    check_dut("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("idle.wt_busy", {31'd0, busy2}, 32'd0);

    // FENCE.I with slow caches and AMO hints.
    cyc(); fi = 1'b1; amo_r = 1'b1; amo_x = 1'b1; #1;
    check_dut("fi.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fi.c0.excl", {31'd0, dc_exc}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      cyc(); df_done = (c == 5); #1;
      check_dut("fi.dflush", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("fi.dflush.excl", {31'd0, dc_exc}, 32'd0);
      check("fi.dflush.res", {31'd0, dc_res}, 32'd1);
    end
    for (int c = 6; c <= 8; c++) begin
      cyc(); df_done = 1'b0; ic_done = (c == 8); #1;
      check_dut("fi.iclear", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check("fi.iclear.excl", {31'd0, dc_exc}, 32'd0);
    end
    cyc(); ic_done = 1'b0; fi = 1'b0; #1;
    check_dut("fi.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fi.done.excl", {31'd0, dc_exc}, 32'd0);
    cyc(); amo_r = 1'b0; #1;
    check_dut("fi.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fi.after.excl", {31'd0, dc_exc}, 32'd1);
    check("fi.after.res", {31'd0, dc_res}, 32'd0);
    amo_x = 1'b0;

    // Data fence with zero-wait caches.
    cyc(); fd = 1'b1; df_done = 1'b1; ic_done = 1'b1; #1;
    check_dut("fd.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    check_dut("fd.c1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); fd = 1'b0; #1;
    check_dut("fd.c2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); df_done = 1'b0; ic_done = 1'b0; #1;
    check_dut("fd.c3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Write-through dcache: FENCE.I skips the flush, data fence goes straight to DONE.
    cyc(); fi2 = 1'b1; ic_done2 = 1'b1; #1;
    check("wt.fi.c0.busy", {31'd0, busy2}, 32'd1);
    cyc(); #1;
    check("wt.fi.c1.flush", {31'd0, dc_fl2}, 32'd0);
    check("wt.fi.c1.iclear", {31'd0, ic_clr2}, 32'd1);
    cyc(); fi2 = 1'b0; ic_done2 = 1'b0; #1;
    check("wt.fi.c2.done", {31'd0, done2}, 32'd1);
    check("wt.fi.c2.flush", {31'd0, dc_fl2}, 32'd0);
    cyc(); fd2 = 1'b1; #1;
    check("wt.fd.c0.busy", {31'd0, busy2}, 32'd1);
    cyc(); fd2 = 1'b0; #1;
    check("wt.fd.c1.done", {31'd0, done2}, 32'd1);
    check("wt.fd.c1.flush", {31'd0, dc_fl2}, 32'd0);
    cyc(); #1;
    check("wt.fd.c2.done", {31'd0, done2}, 32'd0);

    // Reset during I_CLEAR, request still pending afterwards restarts the sequence.
    cyc(); fi = 1'b1; df_done = 1'b1; #1;
    check_dut("rr.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    check_dut("rr.c1", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); RST = 1'b1; #1;
    check_dut("rr.c2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(); RST = 1'b0; #1;
    check_dut("rr.c3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    check_dut("rr.c4", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); ic_done = 1'b1; #1;
    check_dut("rr.c5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(); fi = 1'b0; df_done = 1'b0; ic_done = 1'b0; #1;
    check_dut("rr.c6", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(); #1;
    check_dut("rr.c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef FENCE_TIMEOUT_EN
    // Stuck dcache: watchdog of 8 forces DONE nine cycles after D_FLUSH entry.
    cyc(); fd = 1'b1; amo_x = 1'b1; #1;
    check_dut("to.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++) begin
      cyc(); #1;
      check_dut("to.wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("to.wait.excl", {31'd0, dc_exc}, 32'd0);
    end
    cyc(); fd = 1'b0; #1;
    check_dut("to.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    check("to.done.excl", {31'd0, dc_exc}, 32'd0);
    cyc(); #1;
    check_dut("to.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to.after.excl", {31'd0, dc_exc}, 32'd1);
    amo_x = 1'b0;
`else
    // Without the watchdog a stuck dcache keeps the fence waiting indefinitely.
    cyc(); fd = 1'b1; #1;
    check_dut("nto.c0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      cyc(); #1;
      check_dut("nto.wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    cyc(); df_done = 1'b1; #1;
    check_dut("nto.release", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(); fd = 1'b0; df_done = 1'b0; #1;
    check_dut("nto.done", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fence_cache_sequencer.md
Name: fence_cache_sequencer

Overview:
- Pipeline-side controller that drives the cache control interface (pipeline modport).
- Converts FENCE.I and data-FENCE requests from execute into ordered dcache-flush / icache-clear operations, waits on the caches' done signals, and stalls the pipeline until the sequence completes.
- Also forwards the atomic unit's reservation and exclusive-lock hints to the dcache.
- Sits between the execute/hazard unit (upstream) and the L1 caches (downstream).

Parameters:
- DCACHE_WRITEBACK, 1: 1 = dcache holds dirty lines, so fences flush it; 0 = write-through, so the D_FLUSH phase is skipped.
- TIMEOUT_CYCLES, 1024: watchdog limit per cache phase; used only with FENCE_TIMEOUT_EN.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- fence_i_req  in  1  FENCE.I in execute; level, held until fence_done
- fence_d_req  in  1  data FENCE in execute; level, held until fence_done
- amo_reserve  in  1  LR/SC depends on reservation set
- amo_exclusive  in  1  AMO requests line lock
- fence_busy  out  1  stall request to hazard unit
- fence_done  out  1  one-cycle completion pulse
- fence_timeout  out  1  watchdog expiry pulse, concurrent with fence_done
- icache_clear  out  1  invalidate icache
- icache_flush  out  1  tied 0 (icache is never dirty)
- dcache_clear  out  1  tied 0
- dcache_flush  out  1  write back and invalidate dcache
- dcache_reserve  out  1  = amo_reserve
- dcache_exclusive  out  1  = amo_exclusive & (state==IDLE)
- iclear_done, iflush_done, dclear_done, dflush_done  in  1 each  cache completion levels; iflush_done and dclear_done are ignored

Behaviour:
- Interface: one clock, CLK; reset RST is synchronous and active-high.
- Reset: state goes to IDLE and all registered outputs go to 0 at the next CLK edge.
  - Applies mid-operation too: the in-flight cache request drops and no fence_done is issued.
- FSM states: IDLE, D_FLUSH, I_CLEAR, DONE. Outputs are Moore-decoded from registered state.
  - dcache_flush = (state==D_FLUSH)
  - icache_clear = (state==I_CLEAR)
  - fence_done = (state==DONE)
- IDLE:
  - fence_i_req → D_FLUSH if DCACHE_WRITEBACK, else I_CLEAR.
  - else fence_d_req → D_FLUSH if DCACHE_WRITEBACK, else DONE.
  - Both requests high together are treated as fence_i_req.
- D_FLUSH: hold until dflush_done is sampled 1.
  - Then go to I_CLEAR if the latched op is FENCE.I, else DONE.
  - The op type is latched on leaving IDLE.
- I_CLEAR: hold until iclear_done is sampled 1, then go to DONE.
- DONE: one cycle, unconditionally returns to IDLE.
- Handshake:
  - A cache request is a level held from state entry until the cycle after done is sampled.
  - A done already high on the first cycle of a state is accepted (zero-wait cache).
  - The upstream requester must drop its request in the fence_done cycle, i.e. the pipeline advances. A request still high in IDLE afterwards starts a new fence.
- fence_busy = (state!=IDLE && state!=DONE) || (state==IDLE && (fence_i_req||fence_d_req)).
  - It is combinational, so the stall starts in the same cycle the request appears.
- Minimum latency with zero-wait caches, DCACHE_WRITEBACK=1:
  - FENCE.I: request seen in cycle 0 → fence_done in cycle 3.
  - Data fence: fence_done in cycle 2.
- Requests arriving mid-sequence are ignored until IDLE.
- dcache_reserve passes through in every state. dcache_exclusive is suppressed while a fence is in progress.

Optional Feature:
- FENCE_TIMEOUT_EN defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to D_FLUSH or I_CLEAR and increments each cycle done is 0.
  - When the count reaches TIMEOUT_CYCLES, the FSM goes to DONE and fence_timeout=1 in that DONE cycle.
  - fence_timeout resets to 0.
- FENCE_TIMEOUT_EN undefined: no counter; fence_timeout tied 0; the FSM waits forever for done.

Test Plan:
- Reset with fence_i_req=1, held high for 3 cycles → all outputs 0, state IDLE, no cache request while RST=1.
- FENCE.I, dflush_done 4 cycles after dcache_flush rises, iclear_done 2 cycles after icache_clear rises → dcache_flush high 5 cycles, then icache_clear high 3 cycles, then fence_done pulses exactly once; fence_busy high from the request cycle until DONE.
- Data fence with zero-wait caches → dcache_flush 1 cycle, icache_clear never asserted, fence_done at cycle 2.
- DCACHE_WRITEBACK=0, FENCE.I → dcache_flush never rises, icache_clear in cycle 1, fence_done in cycle 2.
- RST asserted during I_CLEAR → icache_clear 0 next cycle, no fence_done; with fence_i_req still high after reset, a new sequence starts.
- FENCE_TIMEOUT_EN with TIMEOUT_CYCLES=8, dflush_done stuck 0 → fence_done and fence_timeout both pulse 9 cycles after D_FLUSH entry; amo_exclusive=1 gives dcache_exclusive=0 throughout the fence.
